cpu_controller: RTL and testbench

Instruction register, decoder and Moore FSM that sequence the 16-bit datapath, one instruction at a time. The controller latches a 16-bit instruction and, on a start pulse, drives the datapath control strobes cycle by cycle. It also drives register selects and sign-extended immediates, then returns to an idle/wait state. It sits between the top-level CPU wrapper (instruction source, start/wait handshake) and the datapath.

---
 rtl/cpu_pkg.sv | 38 +++
 rtl/cpu_controller_decoder.sv | 26 ++
 rtl/cpu_controller.sv | 150 +++++++++++++++
 tb/tb_cpu_controller.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the 16-bit CPU controller:
// FSM state encoding, opcode/op field values, writeback-mux selects and sign-extension helpers.
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_WAIT      = 3'd0,
        ST_DECODE    = 3'd1,
        ST_WRITE_IMM = 3'd2,
        ST_GET_A     = 3'd3,
        ST_GET_B     = 3'd4,
        ST_ALU       = 3'd5,
        ST_WRITE_REG = 3'd6
    } state_e;

    localparam logic [2:0] OPC_MOV    = 3'b110;
    localparam logic [2:0] OPC_ALU    = 3'b101;

    localparam logic [1:0] OP_MOV_IMM = 2'b10;
    localparam logic [1:0] OP_MOV_REG = 2'b00;
    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_CMP     = 2'b01;
    localparam logic [1:0] OP_AND     = 2'b10;
    localparam logic [1:0] OP_MVN     = 2'b11;

    localparam logic [3:0] VSEL_C     = 4'b0001;
    localparam logic [3:0] VSEL_PC    = 4'b0010;
    localparam logic [3:0] VSEL_IMM8  = 4'b0100;
    localparam logic [3:0] VSEL_MDATA = 4'b1000;

    function automatic logic [15:0] sext8(input logic [7:0] v);
        return {{8{v[7]}}, v};
    endfunction

    function automatic logic [15:0] sext5(input logic [4:0] v);
        return {{11{v[4]}}, v};
    endfunction

endpackage

// File: rtl/cpu_controller_decoder.sv
// Instruction field extraction and immediate sign extension.
// Purely combinational; the instruction register lives in the controller.
module instr_decoder
    import cpu_pkg::*;
(
    input  logic [15:0] ir_i,
    output logic [2:0]  opcode_o,
    output logic [1:0]  op_o,
    output logic [2:0]  rn_o,
    output logic [2:0]  rd_o,
    output logic [1:0]  sh_o,
    output logic [2:0]  rm_o,
    output logic [15:0] sximm8_o,
    output logic [15:0] sximm5_o
);

    assign opcode_o = ir_i[15:13];
    assign op_o     = ir_i[12:11];
    assign rn_o     = ir_i[10:8];
    assign rd_o     = ir_i[7:5];
    assign sh_o     = ir_i[4:3];
    assign rm_o     = ir_i[2:0];
    assign sximm8_o = sext8(ir_i[7:0]);
    assign sximm5_o = sext5(ir_i[4:0]);

endmodule

// File: rtl/cpu_controller.sv
// Instruction register plus Moore FSM that sequences the datapath one instruction at a time.
// Control outputs depend only on state and IR; reset gates the write/load strobes immediately.
module cpu_controller
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] in,
    input  logic        load,
    input  logic        s,
    output logic        w,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic [3:0]  vsel,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  ALUop,
    output logic [1:0]  shift,
    output logic [15:0] sximm8,
    output logic [15:0] sximm5
);

    state_e      state_q, state_d;
    logic [15:0] ir_q;

    logic [2:0] opcode_s, rn_s, rd_s, rm_s;
    logic [1:0] op_s, sh_s;
    logic       is_mov_imm_s, is_mov_reg_s, is_alu_s, is_cmp_s;
    logic       write_s, loada_s, loadb_s, loadc_s, loads_s;
    logic [3:0] vsel_s;

    instr_decoder u_dec (
        .ir_i     (ir_q),
        .opcode_o (opcode_s),
        .op_o     (op_s),
        .rn_o     (rn_s),
        .rd_o     (rd_s),
        .sh_o     (sh_s),
        .rm_o     (rm_s),
        .sximm8_o (sximm8),
        .sximm5_o (sximm5)
    );

    assign is_mov_imm_s = (opcode_s == OPC_MOV) && (op_s == OP_MOV_IMM);
    assign is_mov_reg_s = (opcode_s == OPC_MOV) && (op_s == OP_MOV_REG);
    assign is_alu_s     = (opcode_s == OPC_ALU);
    assign is_cmp_s     = is_alu_s && (op_s == OP_CMP);

    // State and IR registers; IR only captures while idle so it is stable for the whole instruction.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_WAIT;
            ir_q    <= 16'h0000;
        end else begin
            state_q <= state_d;
            if (load && (state_q == ST_WAIT)) begin
                ir_q <= in;
            end else begin
                ir_q <= ir_q;
            end
        end
    end

    // Next-state and Moore control decode.
    always_comb begin
        state_d  = state_q;
        w        = 1'b0;
        readnum  = 3'd0;
        writenum = 3'd0;
        write_s  = 1'b0;
        vsel_s   = VSEL_C;
        loada_s  = 1'b0;
        loadb_s  = 1'b0;
        loadc_s  = 1'b0;
        loads_s  = 1'b0;
        asel     = 1'b0;
        bsel     = 1'b0;
        ALUop    = 2'b00;
        shift    = 2'b00;
        case (state_q)
            ST_WAIT: begin
                w       = 1'b1;
                state_d = s ? ST_DECODE : ST_WAIT;
            end
            ST_DECODE: begin
                if (is_mov_imm_s) begin
                    state_d = ST_WRITE_IMM;
                end else if (is_mov_reg_s) begin
                    state_d = ST_GET_B;
                end else if (is_alu_s) begin
                    state_d = ST_GET_A;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WRITE_IMM: begin
                writenum = rn_s;
                vsel_s   = VSEL_IMM8;
                write_s  = 1'b1;
                state_d  = ST_WAIT;
            end
            ST_GET_A: begin
                readnum = rn_s;
                loada_s = 1'b1;
                state_d = ST_GET_B;
            end
            ST_GET_B: begin
                readnum = rm_s;
                loadb_s = 1'b1;
                shift   = sh_s;
                state_d = ST_ALU;
            end
            ST_ALU: begin
                shift = sh_s;
                asel  = is_mov_reg_s;
                ALUop = is_mov_reg_s ? 2'b00 : op_s;
                // CMP only updates status; nothing is written back.
                if (is_cmp_s) begin
                    loads_s = 1'b1;
                    state_d = ST_WAIT;
                end else begin
                    loadc_s = 1'b1;
                    state_d = ST_WRITE_REG;
                end
            end
            ST_WRITE_REG: begin
                writenum = rd_s;
                vsel_s   = VSEL_C;
                write_s  = 1'b1;
                state_d  = ST_WAIT;
            end
            default: begin
                state_d = ST_WAIT;
            end
        endcase
    end

    assign write = write_s & ~reset;
    assign loada = loada_s & ~reset;
    assign loadb = loadb_s & ~reset;
    assign loadc = loadc_s & ~reset;
    assign loads = loads_s & ~reset;
    assign vsel  = reset ? VSEL_C : vsel_s;

endmodule

// File: tb/tb_cpu_controller.sv
// Directed bench for cpu_controller: per-cycle expected control bundles are queued
// before each instruction runs and popped/compared on every falling edge.
module tb_cpu_controller;

    logic        clk = 1'b0;
    logic        reset, load, s;
    logic [15:0] in;
    logic        w, write, loada, loadb, loadc, loads, asel, bsel;
    logic [2:0]  readnum, writenum;
    logic [3:0]  vsel;
    logic [1:0]  ALUop, shift;
    logic [15:0] sximm8, sximm5;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string      tag;
        logic       w;
        logic       write;
        logic [3:0] vsel;
        logic       la, lb, lc, ls;
        logic       asel;
        logic [1:0] aluop;
        logic [1:0] shift;
        logic       rn_chk;
        logic [2:0] rn;
        logic       wn_chk;
        logic [2:0] wn;
    } exp_t;

    exp_t q[$];

    cpu_controller dut (
        .clk(clk), .reset(reset), .in(in), .load(load), .s(s), .w(w),
        .readnum(readnum), .writenum(writenum), .write(write), .vsel(vsel),
        .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
        .asel(asel), .bsel(bsel), .ALUop(ALUop), .shift(shift),
        .sximm8(sximm8), .sximm5(sximm5)
    );

    always #5 clk = ~clk;

    task automatic push(input string tag, input logic ew, input logic ewr, input logic [3:0] ev,
                        input logic la, input logic lb, input logic lc, input logic ls,
                        input logic ea, input logic [1:0] eop, input logic [1:0] esh,
                        input logic rc, input logic [2:0] rn, input logic wc, input logic [2:0] wn);
        exp_t e;
        e.tag = tag; e.w = ew; e.write = ewr; e.vsel = ev;
        e.la = la; e.lb = lb; e.lc = lc; e.ls = ls;
        e.asel = ea; e.aluop = eop; e.shift = esh;
        e.rn_chk = rc; e.rn = rn; e.wn_chk = wc; e.wn = wn;
        q.push_back(e);
    endtask

    task automatic push_wait(input string tag);
        push(tag, 1'b1, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 3'd0, 1'b0, 3'd0);
    endtask

    task automatic push_decode(input string tag);
        push(tag, 1'b0, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 3'd0, 1'b0, 3'd0);
    endtask

    task automatic check_cycle();
        exp_t        e;
        logic [15:0] obs, expv;
        e    = q.pop_front();
        obs  = {w, write, vsel, loada, loadb, loadc, loads, asel, bsel, ALUop, shift};
        expv = {e.w, e.write, e.vsel, e.la, e.lb, e.lc, e.ls, e.asel, 1'b0, e.aluop, e.shift};
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s ctrl observed=%h expected=%h", e.tag, obs, expv);
        end
        if (e.rn_chk) begin
            checks++;
            assert (readnum === e.rn) else begin
                failures++;
                $error("FAIL %s readnum observed=%0d expected=%0d", e.tag, readnum, e.rn);
            end
        end
        if (e.wn_chk) begin
            checks++;
            assert (writenum === e.wn) else begin
                failures++;
                $error("FAIL %s writenum observed=%0d expected=%0d", e.tag, writenum, e.wn);
            end
        end
    endtask

    task automatic check_imm(input string tag, input logic [15:0] x8, input logic [15:0] x5);
        checks++;
        assert (sximm8 === x8) else begin
            failures++;
            $error("FAIL %s sximm8 observed=%h expected=%h", tag, sximm8, x8);
        end
        checks++;
        assert (sximm5 === x5) else begin
            failures++;
            $error("FAIL %s sximm5 observed=%h expected=%h", tag, sximm5, x5);
        end
    endtask

    // Called on a falling edge in WAIT: load IR, pulse s, then drain the queued expectations.
    task automatic exec(input string tag, input logic [15:0] instr,
                        input logic [15:0] x8, input logic [15:0] x5);
        in = instr; load = 1'b1; s = 1'b0;
        @(negedge clk);
        load = 1'b0; s = 1'b1;
        check_imm(tag, x8, x5);
        checks++;
        assert (w === 1'b1) else begin
            failures++;
            $error("FAIL %s w_before_start observed=%b expected=1", tag, w);
        end
        @(negedge clk);
        s = 1'b0;
        for (int c = 0; c < 16 && q.size() > 0; c++) begin
            check_cycle();
            if (q.size() > 0) @(negedge clk);
        end
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; s = 1'b0; in = 16'h0000;
        @(negedge clk);
        push("reset_hold", 1'b1, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 3'd0, 1'b0, 3'd0);
        check_cycle();
        @(negedge clk);
        reset = 1'b0;
        check_imm("reset_ir", 16'h0000, 16'h0000);

        // MOV R0,#7
        push_decode("movi7_decode");
        push("movi7_wimm", 1'b0, 1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 3'd0, 1'b1, 3'd0);
        push_wait("movi7_done");
        exec("movi7", 16'hD007, 16'h0007, 16'h0007);

        // MOV R1,#-2
        push_decode("movim2_decode");
        push("movim2_wimm", 1'b0, 1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 3'd0, 1'b1, 3'd1);
        push_wait("movim2_done");
        exec("movim2", 16'hD1FE, 16'hFFFE, 16'hFFFE);

        // ADD R2,R1,R0,LSL#1
        push_decode("add_decode");
        push("add_geta", 1'b0, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 3'd1, 1'b0, 3'd0);
        push("add_getb", 1'b0, 1'b0, 4'b0001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 1'b1, 3'd0, 1'b0, 3'd0);
        push("add_alu",  1'b0, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b01, 1'b0, 3'd0, 1'b0, 3'd0);
        push("add_wreg", 1'b0, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 3'd0, 1'b1, 3'd2);
        push_wait("add_done");
        exec("add", 16'hA148, 16'h0048, 16'h0008);

        // CMP R1,R0
        push_decode("cmp_decode");
        push("cmp_geta", 1'b0, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 3'd1, 1'b0, 3'd0);
        push("cmp_getb", 1'b0, 1'b0, 4'b0001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 3'd0, 1'b0, 3'd0);
        push("cmp_alu",  1'b0, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01, 2'b00, 1'b0, 3'd0, 1'b0, 3'd0);
        push_wait("cmp_done");
        exec("cmp", 16'hA900, 16'h0000, 16'h0000);

        // MOV R3,R0,LSR#1
        push_decode("movr_decode");
        push("movr_getb", 1'b0, 1'b0, 4'b0001, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 1'b1, 3'd0, 1'b0, 3'd0);
        push("movr_alu",  1'b0, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 2'b10, 1'b0, 3'd0, 1'b0, 3'd0);
        push("movr_wreg", 1'b0, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 3'd0, 1'b1, 3'd3);
        push_wait("movr_done");
        exec("movr", 16'hC070, 16'h0070, 16'hFFF0);

        // Unsupported opcode 111 falls straight back to WAIT
        push_decode("bad_decode");
        push_wait("bad_done");
        exec("bad", 16'hE000, 16'h0000, 16'h0000);

        // Reset during GET_B of ADD aborts the instruction
        in = 16'hA148; load = 1'b1;
        @(negedge clk);
        load = 1'b0; s = 1'b1;
        @(negedge clk);
        s = 1'b0;
        push_decode("rst_decode");
        check_cycle();
        @(negedge clk);
        push("rst_geta", 1'b0, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 3'd1, 1'b0, 3'd0);
        check_cycle();
        @(negedge clk);
        reset = 1'b1;
        #1;
        push("rst_getb_gated", 1'b0, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 1'b0, 3'd0, 1'b0, 3'd0);
        check_cycle();
        @(negedge clk);
        reset = 1'b0;
        push_wait("rst_wait");
        check_cycle();
        check_imm("rst_ir_clear", 16'h0000, 16'h0000);

        // load while busy must not disturb the IR
        in = 16'hD007; load = 1'b1;
        @(negedge clk);
        load = 1'b0; s = 1'b1;
        @(negedge clk);
        s = 1'b0; in = 16'hFFFF; load = 1'b1;
        push_decode("guard_decode");
        check_cycle();
        @(negedge clk);
        push("guard_wimm", 1'b0, 1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 3'd0, 1'b1, 3'd0);
        check_cycle();
        check_imm("guard_ir_busy", 16'h0007, 16'h0007);
        @(negedge clk);
        push_wait("guard_wait");
        check_cycle();
        check_imm("guard_ir_after", 16'h0007, 16'h0007);
        load = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
